// File: rtl/obj_spawner.sv
// obj_spawner: allocates bullet/enemy slots from fire requests and a periodic spawn timer.
// Latency: one clk from request/timer expiry to the registered flag and pulse outputs.
// Backpressure: fire_req stays pending while cooling down or all bullet slots are full.
// Build option: define SPAWN_LFSR_EN to start the enemy slot search at an LFSR-chosen index.
module obj_spawner #(
   parameter int N_BULLET      = 5,
   parameter int N_ENEMY       = 6,
   parameter int SPAWN_PERIOD  = 50,
   parameter int FIRE_COOLDOWN = 8,
   localparam int BW = (N_BULLET > 1) ? $clog2(N_BULLET) : 1,
   localparam int EW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                game_start,
   input  logic                dead,
   input  logic                fire_req,
   output logic                fire_ack,
   output logic [BW-1:0]       fire_slot,
   input  logic [N_BULLET-1:0] bullet_done,
   input  logic [N_ENEMY-1:0]  enemy_kill,
   output logic [N_BULLET-1:0] bullet_active,
   output logic [N_ENEMY-1:0]  enemy_active,
   output logic                spawn_pulse,
   output logic [EW-1:0]       spawn_slot,
   output logic                spawn_miss,
   output logic [1:0]          state
);

   localparam int TW = $clog2(SPAWN_PERIOD);
   localparam int CW = $clog2(FIRE_COOLDOWN + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DEAD = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [N_BULLET-1:0] bact_q, bact_d;
   logic [N_ENEMY-1:0]  eact_q, eact_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [CW-1:0]       cool_q, cool_d;
   logic                fire_ack_q, fire_ack_d;
   logic [BW-1:0]       fire_slot_q, fire_slot_d;
   logic                spawn_pulse_q, spawn_pulse_d;
   logic [EW-1:0]       spawn_slot_q, spawn_slot_d;
   logic                spawn_miss_q, spawn_miss_d;

   logic                b_free_vld;
   logic [BW-1:0]       b_free_idx;
   logic                e_free_vld;
   logic [EW-1:0]       e_free_idx;

   // Lowest-index free bullet slot, from registered flags only.
   always_comb begin
      b_free_vld = 1'b0;
      b_free_idx = '0;
      for (int i = N_BULLET - 1; i >= 0; i--) begin
         if (!bact_q[i]) begin
            b_free_vld = 1'b1;
            b_free_idx = BW'(i);
         end
      end
   end

`ifdef SPAWN_LFSR_EN
   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   // Free-running LFSR (x^8+x^6+x^5+x^4+1) stepping every clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= 8'h5A;
      else       lfsr_q <= lfsr_d;
   end

   // First free enemy slot searching upward from lfsr % N_ENEMY, wrapping.
   always_comb begin
      int start;
      int dist;
      int best;
      e_free_vld = 1'b0;
      e_free_idx = '0;
      start      = int'(lfsr_q) % N_ENEMY;
      best       = N_ENEMY;
      for (int i = 0; i < N_ENEMY; i++) begin
         dist = (i - start + N_ENEMY) % N_ENEMY;
         if (!eact_q[i] && dist < best) begin
            best       = dist;
            e_free_vld = 1'b1;
            e_free_idx = EW'(i);
         end
      end
   end
`else
   // Lowest-index free enemy slot.
   always_comb begin
      e_free_vld = 1'b0;
      e_free_idx = '0;
      for (int i = N_ENEMY - 1; i >= 0; i--) begin
         if (!eact_q[i]) begin
            e_free_vld = 1'b1;
            e_free_idx = EW'(i);
         end
      end
   end
`endif

   // Game FSM, slot set/clear, fire cooldown and spawn timer next-state.
   always_comb begin
      state_d       = state_q;
      bact_d        = bact_q & ~bullet_done;
      eact_d        = eact_q & ~enemy_kill;
      timer_d       = '0;
      cool_d        = '0;
      fire_ack_d    = 1'b0;
      fire_slot_d   = '0;
      spawn_pulse_d = 1'b0;
      spawn_slot_d  = '0;
      spawn_miss_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (game_start && !dead) state_d = S_RUN;
         end
         S_RUN: begin
            if (dead) begin
               // Death wipes the field on the same edge that enters DEAD.
               state_d = S_DEAD;
               bact_d  = '0;
               eact_d  = '0;
            end else begin
               cool_d = (cool_q != '0) ? cool_q - 1'b1 : '0;
               if (fire_req && (cool_q == '0) && b_free_vld) begin
                  bact_d[b_free_idx] = 1'b1;
                  fire_ack_d         = 1'b1;
                  fire_slot_d        = b_free_idx;
                  cool_d             = CW'(FIRE_COOLDOWN);
               end
               timer_d = timer_q + 1'b1;
               if (timer_q == TW'(SPAWN_PERIOD - 1)) begin
                  timer_d = '0;
                  if (e_free_vld) begin
                     eact_d[e_free_idx] = 1'b1;
                     spawn_pulse_d      = 1'b1;
                     spawn_slot_d       = e_free_idx;
                  end else begin
                     spawn_miss_d = 1'b1;
                  end
               end
            end
         end
         S_DEAD: begin
            if (game_start && !dead) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         bact_q        <= '0;
         eact_q        <= '0;
         timer_q       <= '0;
         cool_q        <= '0;
         fire_ack_q    <= 1'b0;
         fire_slot_q   <= '0;
         spawn_pulse_q <= 1'b0;
         spawn_slot_q  <= '0;
         spawn_miss_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         bact_q        <= bact_d;
         eact_q        <= eact_d;
         timer_q       <= timer_d;
         cool_q        <= cool_d;
         fire_ack_q    <= fire_ack_d;
         fire_slot_q   <= fire_slot_d;
         spawn_pulse_q <= spawn_pulse_d;
         spawn_slot_q  <= spawn_slot_d;
         spawn_miss_q  <= spawn_miss_d;
      end
   end

   assign state         = state_q;
   assign bullet_active = bact_q;
   assign enemy_active  = eact_q;
   assign fire_ack      = fire_ack_q;
   assign fire_slot     = fire_slot_q;
   assign spawn_pulse   = spawn_pulse_q;
   assign spawn_slot    = spawn_slot_q;
   assign spawn_miss    = spawn_miss_q;

endmodule
